// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU; simple ops return in one cycle, MUL/DIV iterate one bit per cycle.
// Optional macro ALU_SEQ_EARLY_OUT_EN: MUL finishes as soon as the remaining multiplier bits are zero.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             lt,
  output logic             gt,
  output logic             overflow
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH + 1);
  localparam int unsigned W2  = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_SEQ = 4'd2,  OP_SLT = 4'd3;
  localparam logic [3:0] OP_SGT  = 4'd4,  OP_AND  = 4'd5,  OP_OR  = 4'd6,  OP_NOT = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8,  OP_SGTU = 4'd9,  OP_SLL = 4'd10, OP_SRL = 4'd11;
  localparam logic [3:0] OP_SLA  = 4'd12, OP_SRA  = 4'd13, OP_MUL = 4'd14, OP_DIV = 4'd15;

`ifdef ALU_SEQ_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             zero_q, zero_d, lt_q, lt_d, gt_q, gt_d, overflow_q, overflow_d;
  logic [W2-1:0]    acc_q, acc_d, mc_q, mc_d;
  logic [WIDTH-1:0] mp_q, mp_d;
  logic             neg_q, neg_d, is_div_q, is_div_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, diff, a_mag, b_mag, simple_res, quo, fin_res;
  logic             lt_c, gt_c, simple_ovf, accept, fin, fin_ovf, mul_ovf, early_done;
  logic [WIDTH:0]   rem_sh, trial;
  logic [W2-1:0]    step_acc, step_mc, prod;
  logic [WIDTH-1:0] step_mp;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign zero      = zero_q;
  assign lt        = lt_q;
  assign gt        = gt_q;
  assign overflow  = overflow_q;

  assign shamt = b[SHW-1:0];
  assign sum   = a + b;
  assign diff  = a - b;
  assign lt_c  = $signed(a) < $signed(b);
  assign gt_c  = $signed(a) > $signed(b);
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // Single-cycle operations, computed straight from the presented operands.
  always_comb begin
    simple_res = '0;
    simple_ovf = 1'b0;
    case (alu_op)
      OP_ADD: begin
        simple_res = sum;
        simple_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        simple_res = diff;
        simple_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SEQ:         simple_res = WIDTH'(a == b);
      OP_SLT:         simple_res = WIDTH'(lt_c);
      OP_SGT:         simple_res = WIDTH'(gt_c);
      OP_AND:         simple_res = a & b;
      OP_OR:          simple_res = a | b;
      OP_NOT:         simple_res = ~a;
      OP_SLTU:        simple_res = WIDTH'(a < b);
      OP_SGTU:        simple_res = WIDTH'(a > b);
      OP_SLL, OP_SLA: simple_res = a << shamt;
      OP_SRL:         simple_res = a >> shamt;
      OP_SRA:         simple_res = WIDTH'($signed(a) >>> shamt);
      default:        simple_res = '0;
    endcase
  end

  // One iteration: shift-add multiply (mc = shifted multiplicand) or restoring divide (mc low half = quotient).
  always_comb begin
    rem_sh = {acc_q[WIDTH-1:0], mc_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, mp_q};
    if (is_div_q) begin
      step_acc = trial[WIDTH] ? W2'(rem_sh) : W2'(trial);
      step_mc  = {mc_q[W2-2:0], ~trial[WIDTH]};
      step_mp  = mp_q;
    end else begin
      step_acc = mp_q[0] ? acc_q + mc_q : acc_q;
      step_mc  = mc_q << 1;
      step_mp  = mp_q >> 1;
    end
    prod       = neg_q ? -step_acc : step_acc;
    quo        = neg_q ? -step_mc[WIDTH-1:0] : step_mc[WIDTH-1:0];
    mul_ovf    = ~((&prod[W2-1:WIDTH-1]) | ~(|prod[W2-1:WIDTH-1]));
    early_done = EARLY & ~is_div_q & ~(|step_mp);
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    zero_d      = zero_q;
    lt_d        = lt_q;
    gt_d        = gt_q;
    overflow_d  = overflow_q;
    acc_d       = acc_q;
    mc_d        = mc_q;
    mp_d        = mp_q;
    neg_d       = neg_q;
    is_div_d    = is_div_q;
    cnt_d       = cnt_q;
    fin         = 1'b0;
    fin_res     = '0;
    fin_ovf     = 1'b0;

    case (state_q)
      BUSY: begin
        acc_d = step_acc;
        mc_d  = step_mc;
        mp_d  = step_mp;
        cnt_d = cnt_q - CW'(1);
        if ((cnt_q == CW'(1)) || early_done) begin
          fin     = 1'b1;
          fin_res = is_div_q ? quo : prod[WIDTH-1:0];
          fin_ovf = is_div_q ? 1'b0 : mul_ovf;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      lt_d        = lt_c;
      gt_d        = gt_c;
      out_valid_d = 1'b0;
      if (alu_op == OP_MUL) begin
        if (EARLY && ((a == '0) || (b == '0))) begin
          fin = 1'b1;
        end else begin
          state_d  = BUSY;
          acc_d    = '0;
          mc_d     = W2'(a_mag);
          mp_d     = b_mag;
          neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
          is_div_d = 1'b0;
          cnt_d    = CW'(WIDTH);
        end
      end else if (alu_op == OP_DIV) begin
        if (b == '0) begin
          fin     = 1'b1;
          fin_res = '1;
        end else if ((a == MIN_VAL) && (b == '1)) begin
          fin     = 1'b1;
          fin_res = MIN_VAL;
          fin_ovf = 1'b1;
        end else begin
          state_d  = BUSY;
          acc_d    = '0;
          mc_d     = W2'(a_mag);
          mp_d     = b_mag;
          neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
          is_div_d = 1'b1;
          cnt_d    = CW'(WIDTH);
        end
      end else begin
        fin     = 1'b1;
        fin_res = simple_res;
        fin_ovf = simple_ovf;
      end
    end

    if (fin) begin
      state_d     = DONE;
      out_valid_d = 1'b1;
      alu_out_d   = fin_res;
      zero_d      = ~(|fin_res);
      overflow_d  = fin_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      zero_q      <= 1'b0;
      lt_q        <= 1'b0;
      gt_q        <= 1'b0;
      overflow_q  <= 1'b0;
      acc_q       <= '0;
      mc_q        <= '0;
      mp_q        <= '0;
      neg_q       <= 1'b0;
      is_div_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      zero_q      <= zero_d;
      lt_q        <= lt_d;
      gt_q        <= gt_d;
      overflow_q  <= overflow_d;
      acc_q       <= acc_d;
      mc_q        <= mc_d;
      mp_q        <= mp_d;
      neg_q       <= neg_d;
      is_div_q    <= is_div_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 32-bit combinational ALU.
- Keeps the 16-op encoding (ADD..DIV). Single-cycle ops are registered.
- MUL and DIV run iteratively: shift-add multiply, restoring divide.
- Sits in the execute stage between operand fetch and writeback; stalls the pipe via ready/valid.

Parameters:
WIDTH, 32, operand/result width; power of two, >= 8
SHW, $clog2(WIDTH), localparam; shift-amount bits taken from B[SHW-1:0]

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  operands and op presented
in_ready  output  1  block can accept this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
alu_op  input  4  operation, encoding below
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
alu_out  output  WIDTH  result
zero  output  1  alu_out == 0
lt  output  1  signed a < b, captured at accept
gt  output  1  signed a > b, captured at accept
overflow  output  1  signed overflow (see rules)

Behaviour:
- Reset: one clock; reset is synchronous, active-low (clk, rst_n).
  - rst_n low at a clk edge forces state IDLE.
  - out_valid=0, alu_out=0, zero/lt/gt/overflow=0, in_ready=1 after reset.
  - Reset mid-MUL/DIV aborts the operation; no result is produced.
- Op encoding:
  - 0 ADD, 1 SUB, 2 SEQ, 3 SLT, 4 SGT, 5 AND, 6 OR, 7 NOT(a).
  - 8 SLTU, 9 SGTU, 10 SLL, 11 SRL, 12 SLA (= SLL), 13 SRA.
  - 14 MUL (signed, low WIDTH bits), 15 DIV (signed, truncate toward zero).
- Shifts: amount = b[SHW-1:0]; upper bits of b ignored.
- Accept condition: in_valid & in_ready. Operands are latched; later input changes are ignored.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, accept simple op (0-13) -> DONE next cycle. Latency 1: out_valid in cycle N+1.
  - IDLE, accept MUL or DIV -> BUSY with iteration counter = WIDTH. Each BUSY cycle processes one bit.
  - BUSY, counter reaches 0 -> DONE. out_valid in cycle N+WIDTH+1.
  - DONE: outputs held stable while out_ready=0. out_ready=1 -> IDLE, or directly to the next op if a new one is accepted the same cycle.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This gives back-to-back single-cycle throughput; in_ready=0 in BUSY.
- Overflow rules:
  - ADD/SUB: signed overflow from operand/result sign bits.
  - MUL: 1 if the full 2*WIDTH signed product is not representable in WIDTH bits.
  - DIV: 1 only for MIN / -1.
  - All other ops: 0.
- MUL/DIV sign handling: operate on magnitudes, then fix signs at completion.
- DIV special cases, both bypassing BUSY (latency 1):
  - b==0: alu_out = all ones, overflow=0.
  - a==MIN, b==-1: alu_out = MIN, overflow=1.
- zero is computed from the final alu_out. lt/gt are registered at accept and presented with the result.

Optional Feature:
- Macro: ALU_SEQ_EARLY_OUT_EN.
- Defined: MUL ends in DONE as soon as the remaining multiplier magnitude bits are all zero. Latency = 1 + index of the highest set bit of |b| + 1. |b|==0 or a==0 completes in 1 cycle.
- DIV is unaffected.
- Undefined: MUL always takes WIDTH BUSY cycles.

Test Plan (WIDTH=32 unless stated):
- Reset: drive rst_n low 2 cycles during a MUL in BUSY -> next cycle out_valid=0, in_ready=1, alu_out=0, and no stale result afterwards.
- ADD back-to-back, out_ready=1:
  - 0x7FFFFFFF+1 -> alu_out=0x80000000, overflow=1, out_valid at N+1.
  - Next-cycle ADD 5+(-5) -> alu_out=0, zero=1, out_valid at N+2.
- MUL -3*7 -> 0xFFFFFFEB, overflow=0, out_valid exactly 33 cycles after accept. in_ready=0 during BUSY.
- MUL 0x10000*0x10000 -> alu_out=0, overflow=1, zero=1.
  - With ALU_SEQ_EARLY_OUT_EN, MUL 9*2 returns 18 in 3 cycles.
- DIV cases:
  - -7/2 -> 0xFFFFFFFD.
  - 5/0 -> 0xFFFFFFFF, latency 1.
  - 0x80000000/0xFFFFFFFF -> 0x80000000, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after SRA 0x80000000>>>b=0x21 -> alu_out stable at 0xC0000000, in_ready=0. Raise out_ready with in_valid -> new op accepted the same cycle.
- WIDTH=8 build: SLT 0x80 vs 0x01 -> alu_out=1, lt=1. SLTU on the same operands -> 0, gt=0.
